// File: rtl/pmt_fifo_n.sv
// DEPTH-stage permit-gated token pipeline with drive/free handshake and per-stage fire pulses.
// Latency: a token accepted at edge E reaches stage DEPTH-1 after edge E+DEPTH-1 (all permits high).
// Backpressure: i_freeNext ripples combinationally back to o_free for zero-bubble streaming.
module pmt_fifo_n #(
    parameter int DEPTH  = 4,
    parameter int WIDTH  = 8,
    parameter bit PMT_EN = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DEPTH-1:0]           pmt,
    input  logic                       i_drive,
    input  logic [WIDTH-1:0]           i_data,
    output logic                       o_free,
    output logic                       o_driveNext,
    output logic [WIDTH-1:0]           o_data,
    input  logic                       i_freeNext,
    output logic [DEPTH-1:0]           o_fire,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int CW = $clog2(DEPTH+1);

    logic [DEPTH-1:0] full_q;
    logic [DEPTH-1:0] full_nxt;
    logic [DEPTH-1:0] perm;
    logic [DEPTH-1:0] move;
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_nxt;
    logic             accept;

    assign perm = PMT_EN ? pmt : {DEPTH{1'b1}};

    // Evaluated from the output end so each stage sees whether its successor vacates.
    always_comb begin
        move            = '0;
        move[DEPTH-1]   = full_q[DEPTH-1] & perm[DEPTH-1] & i_freeNext;
        for (int k = DEPTH - 2; k >= 0; k--) begin
            move[k] = full_q[k] & perm[k] & (~full_q[k+1] | move[k+1]);
        end
    end

    assign o_free      = ~full_q[0] | move[0];
    assign accept      = i_drive & o_free;
    assign o_driveNext = full_q[DEPTH-1] & perm[DEPTH-1];
    assign o_data      = data_q[DEPTH-1];
    assign o_fire      = move;
    assign o_count     = count_q;

    always_comb begin
        full_nxt    = '0;
        full_nxt[0] = accept | (full_q[0] & ~move[0]);
        for (int k = 1; k < DEPTH; k++) begin
            full_nxt[k] = move[k-1] | (full_q[k] & ~move[k]);
        end
        count_nxt = '0;
        for (int k = 0; k < DEPTH; k++) begin
            count_nxt = count_nxt + CW'(full_nxt[k]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full_q  <= '0;
            count_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            full_q  <= full_nxt;
            count_q <= count_nxt;
            if (accept) begin
                data_q[0] <= i_data;
            end
            for (int k = 1; k < DEPTH; k++) begin
                if (move[k-1]) begin
                    data_q[k] <= data_q[k-1];
                end
            end
        end
    end

endmodule

// File: doc/pmt_fifo_n.md
Name: pmt_fifo_n

Overview:
- Clocked, parametrised successor to the single-stage permit-gated FIFO. It is a DEPTH-stage token pipeline that carries a WIDTH-bit payload.
- A per-stage permit (pmt) bit gates each stage's advance. A per-stage fire pulse marks each advance.
- Uses the drive/free handshake: upstream is i_drive/o_free, downstream is o_driveNext/i_freeNext.
- Sits between control-path producers and consumers. Replaces chains of single-stage permit FIFOs in synchronous regions.

Parameters:
- DEPTH, 4, number of stages; legal range 1 to 16.
- WIDTH, 8, payload bits per token; legal minimum 1.
- PMT_EN, 1, 1 = per-stage permit honoured; 0 = pmt ignored and treated as all-ones.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low; clears all state.
- pmt  input  DEPTH  permit per stage; bit k gates the advance out of stage k.
- i_drive  input  1  upstream offers a token this cycle.
- i_data  input  WIDTH  payload accompanying i_drive.
- o_free  output  1  stage 0 can accept a token this cycle.
- o_driveNext  output  1  a token is offered downstream.
- o_data  output  WIDTH  payload of stage DEPTH-1.
- i_freeNext  input  1  downstream accepts the token this cycle.
- o_fire  output  DEPTH  bit k pulses for one cycle when the token in stage k advances.
- o_count  output  clog2(DEPTH+1)  number of occupied stages.

Behaviour:
- State: full[k] and data[k] for k = 0..DEPTH-1. Stage 0 is the input side; stage DEPTH-1 is the output side.
- Effective permit: p[k] = pmt[k] when PMT_EN = 1, otherwise 1.
- Output offer: o_driveNext = full[DEPTH-1] & p[DEPTH-1]; o_data = data[DEPTH-1].
- Advance terms:
  - move[DEPTH-1] = o_driveNext & i_freeNext.
  - For k < DEPTH-1: move[k] = full[k] & p[k] & (~full[k+1] | move[k+1]).
- Fire and upstream ready: o_fire[k] = move[k]; o_free = ~full[0] | move[0]. Both are combinational.
- Ripple path: move ripples combinationally from i_freeNext to o_free. This is deliberate: it gives zero-bubble throughput.
- Upstream accept: the transfer happens when i_drive & o_free. At that edge, data[0] <= i_data and full[0] <= 1.
- Stage k+1 update at the edge: when move[k], data[k+1] <= data[k] and full[k+1] <= 1. When move[k+1] without move[k], full[k+1] <= 0.
- Stage 0 clears at the edge when move[0] occurs without an accept.
- Data registers load only on a transfer into them; otherwise they hold.
- Latency: a token accepted at edge E occupies stage k after edge E+k, with all permits high and the path clear. o_driveNext is asserted in the cycle after edge E+DEPTH-1.
- Throughput: 1 token/cycle when all p = 1 and i_freeNext = 1.
- Order: strict FIFO. There is no overtaking, duplication or loss.
- o_count: popcount of full, registered alongside full. Range is 0..DEPTH.
- Full condition: o_free = 0 exactly when full[0] = 1 and move[0] = 0. When i_drive is high while o_free = 0, the token is ignored and state is unchanged.
- Empty condition: o_driveNext = 0 and o_fire = 0; o_free = 1.
- Permit low: pmt[k] = 0 holds stage k regardless of downstream. Upstream stages back-fill up to stage k. When the permit returns, the advance resumes in the same cycle.
- Simultaneous push and pop on a full FIFO: with i_drive = 1 and a chain of moves reaching stage 0, the push is accepted. o_count is unchanged.
- DEPTH = 1: the single stage is both input and output; o_free = ~full[0] | move[0].
- Reset (rst = 0 at any time, including mid-transfer):
  - full = 0, data = 0, o_count = 0.
  - o_driveNext = 0, o_fire = 0, o_data = 0, o_free = 1.
  - In-flight tokens are discarded. The first accept is allowed on the first edge after rst deasserts.
- Must not produce X on any output after reset for any permit or handshake combination.

Test Plan:
- Reset then single token: DEPTH = 4, pmt = 4'hF, i_freeNext = 1, push 8'hA5 at edge 0 -> o_driveNext = 1 with o_data = 8'hA5 after edge 3. o_fire bits pulse 0, 1, 2, 3 on successive cycles.
- Streaming: push 0x01..0x10 back-to-back with i_freeNext = 1 and pmt = 4'hF -> o_free stays 1. Outputs 0x01..0x10 arrive in order, one per cycle, with no bubbles.
- Fill/full: i_freeNext = 0, push 6 tokens -> o_count reaches 4, o_free = 0 after the 4th accept, and the 5th and 6th are ignored. Raising i_freeNext drains the 4 tokens in order and o_count returns to 0.
- Permit stall: pmt = 4'b1011 with a continuous stream -> the stage-2 token holds and stages 0-1 back-fill. o_fire[2] = 0 while stalled. Restoring pmt = 4'hF resumes flow with no loss.
- PMT_EN = 0: pmt = 0 -> behaves exactly like the all-permit case in the first test.
- Mid-operation reset: assert rst = 0 with 3 tokens held -> o_count = 0, o_driveNext = 0 and o_free = 1 immediately (asynchronous). A new push after release emerges alone.
